// File: rtl/nn_weight_sequencer.sv
// nn_weight_sequencer
// Streams the signed 3-bit weights of one fully-connected layer to the
// ciphertext-by-weight product stage. For every input node i and every
// ciphertext word of that node, the OUT_NODES weights W[i][0..OUT_NODES-1]
// are read from a synchronous weight RAM and delivered in order.
//
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   start_in              start pulse (honoured only when idle)
//   in_nodes_in           input-node count, latched at start
//   ct_words_in           ciphertext words per node, latched at start
//   busy_out / done_out   layer in progress / one-cycle completion pulse
//   w_rd_en_out           weight RAM read enable
//   w_rd_addr_out         weight RAM address (i*OUT_NODES + j)
//   w_rd_data_in          RAM data, RD_LATENCY cycles after the read
//   weights_valid_out     beat valid
//   weights_ready_in      downstream ready
//   weights_out           weight of the beat (bit-exact RAM copy)
//   weights_idx_out       output-node index j of the beat
//   word_idx_out          ciphertext word index of the beat
//   node_idx_out          input-node index i of the beat
//
// Handshake: a beat transfers in every cycle where weights_valid_out and
// weights_ready_in are both high; while ready is low the beat and its tags
// are held unchanged, and valid never drops once raised until transfer.
module nn_weight_sequencer #(
    parameter int OUT_NODES    = 10,
    parameter int MAX_IN_NODES = 784,
    parameter int ADDR_W       = 14,
    parameter int RD_LATENCY   = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic [9:0]        in_nodes_in,
    input  logic [9:0]        ct_words_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              w_rd_en_out,
    output logic [ADDR_W-1:0] w_rd_addr_out,
    input  logic [2:0]        w_rd_data_in,
    output logic              weights_valid_out,
    output logic [2:0]        weights_out,
    output logic [5:0]        weights_idx_out,
    output logic [9:0]        node_idx_out,
    output logic [9:0]        word_idx_out,
    input  logic              weights_ready_in
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2   // empty layer: one busy cycle, then done
    } state_t;

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;
    localparam logic [5:0] J_LAST = 6'(OUT_NODES - 1);
    localparam logic [9:0] MAX_N  = 10'(MAX_IN_NODES);

    state_t state_q, state_d;
    logic   done_q, done_d;

    logic [9:0] n_nodes, n_words;

    // Issue-side counters; base tracks ii*OUT_NODES without a multiplier.
    logic [5:0]        ij;
    logic [9:0]        iw, ii;
    logic [ADDR_W-1:0] base;
    logic              issue_done;

    logic [RD_LATENCY-1:0] vld_pipe;
    logic [CW-1:0]         inflight;

    logic [2:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    // Output-side counters regenerate the beat tags in delivery order.
    logic [5:0] oj;
    logic [9:0] ow, oi;

    logic rd_en, push, pop, valid, last_beat;

    always_comb begin
        inflight = '0;
        for (int k = 0; k < RD_LATENCY; k++) begin
            inflight = inflight + CW'(vld_pipe[k]);
        end
    end

    always_comb begin
        valid     = (count != '0);
        pop       = valid && weights_ready_in;
        push      = vld_pipe[RD_LATENCY-1];
        // Credit check: entries held plus reads in flight must stay within
        // the FIFO, so returning data always has a slot.
        rd_en     = (state_q == RUN) && !issue_done &&
                    ((count + inflight) < CW'(FIFO_DEPTH));
        last_beat = (oj == J_LAST) && (ow == n_words - 10'd1) &&
                    (oi == n_nodes - 10'd1);
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    if (in_nodes_in == '0 || ct_words_in == '0) state_d = ZERO;
                    else                                        state_d = RUN;
                end
            end
            RUN: begin
                if (pop && last_beat) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            ZERO: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            n_nodes    <= '0;
            n_words    <= '0;
            ij         <= '0;
            iw         <= '0;
            ii         <= '0;
            base       <= '0;
            issue_done <= 1'b0;
            vld_pipe   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            oj         <= '0;
            ow         <= '0;
            oi         <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;

            vld_pipe[0] <= rd_en;
            for (int k = 1; k < RD_LATENCY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
            end

            if (state_q == IDLE && start_in) begin
                n_nodes    <= (in_nodes_in > MAX_N) ? MAX_N : in_nodes_in;
                n_words    <= ct_words_in;
                ij         <= '0;
                iw         <= '0;
                ii         <= '0;
                base       <= '0;
                issue_done <= 1'b0;
                oj         <= '0;
                ow         <= '0;
                oi         <= '0;
            end

            if (rd_en) begin
                if (ij == J_LAST) begin
                    ij <= '0;
                    if (iw == n_words - 10'd1) begin
                        iw <= '0;
                        if (ii == n_nodes - 10'd1) begin
                            issue_done <= 1'b1;
                        end else begin
                            ii   <= ii + 10'd1;
                            base <= base + ADDR_W'(OUT_NODES);
                        end
                    end else begin
                        iw <= iw + 10'd1;
                    end
                end else begin
                    ij <= ij + 6'd1;
                end
            end

            if (push) begin
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end

            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
                if (oj == J_LAST) begin
                    oj <= '0;
                    if (ow == n_words - 10'd1) begin
                        ow <= '0;
                        oi <= oi + 10'd1;
                    end else begin
                        ow <= ow + 10'd1;
                    end
                end else begin
                    oj <= oj + 6'd1;
                end
            end

            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: nothing reaches the outputs unless counted valid.
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem[wr_ptr] <= w_rd_data_in;
        end
    end

    always_comb begin
        busy_out          = (state_q == RUN) || (state_q == ZERO);
        done_out          = done_q;
        w_rd_en_out       = rd_en;
        w_rd_addr_out     = rd_en ? (base + ADDR_W'(ij)) : '0;
        weights_valid_out = valid;
        weights_out       = valid ? fifo_mem[rd_ptr] : '0;
        weights_idx_out   = valid ? oj : '0;
        word_idx_out      = valid ? ow : '0;
        node_idx_out      = valid ? oi : '0;
    end

endmodule

// File: tb/tb_nn_weight_sequencer.sv
// Bench for nn_weight_sequencer: RAM model with fixed read latency, an
// expected-beat and expected-address scoreboard built from nested loops over
// (node, word, j), and one task per scenario.
module tb_nn_weight_sequencer;
  localparam int OUT = 10;
  localparam int DEPTH = 4;
  localparam int LAT = 2;
  localparam int AW = 14;

  logic clk, rst, start, ready;
  logic [9:0] in_nodes, ct_words;
  logic busy, done, rd_en, valid;
  logic [AW-1:0] rd_addr;
  logic [2:0] rd_data, w_out;
  logic [5:0] j_idx;
  logic [9:0] n_idx, w_idx;

  nn_weight_sequencer #(.OUT_NODES(OUT), .MAX_IN_NODES(784), .ADDR_W(AW),
                        .RD_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start),
    .in_nodes_in(in_nodes), .ct_words_in(ct_words),
    .busy_out(busy), .done_out(done),
    .w_rd_en_out(rd_en), .w_rd_addr_out(rd_addr), .w_rd_data_in(rd_data),
    .weights_valid_out(valid), .weights_out(w_out), .weights_idx_out(j_idx),
    .node_idx_out(n_idx), .word_idx_out(w_idx), .weights_ready_in(ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // weight RAM model: data for an address appears LAT cycles after it is presented
  logic [2:0] ram [0:(1<<AW)-1];
  logic [AW-1:0] a_d [0:LAT-1];
  always @(posedge clk) begin
    a_d[0] <= rd_addr;
    for (int k = 1; k < LAT; k++) a_d[k] <= a_d[k-1];
  end
  assign rd_data = ram[a_d[LAT-1]];

  // scoreboard
  logic [28:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int n_cmp = 0, n_bad = 0;
  bit sb_en = 0;
  int beats = 0, issued = 0;
  bit prev_stall = 0;
  logic [28:0] prev_beat;
  logic [AW-1:0] last_addr;
  logic [28:0] cur, e;
  logic [AW-1:0] ea;

  always @(negedge clk) begin
    if (sb_en) begin
      cur = {w_out, j_idx, w_idx, n_idx};
      if (rd_en) begin
        n_cmp++;
        if (exp_addr_q.size() == 0) begin
          n_bad++; $display("FAIL read_addr: unexpected read at %0d, none required", rd_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          if (rd_addr !== ea) begin
            n_bad++; $display("FAIL read_addr: got %0d required %0d", rd_addr, ea);
          end
        end
        issued++;
        last_addr = rd_addr;
        n_cmp++;
        if (issued - beats > DEPTH) begin
          n_bad++; $display("FAIL outstanding: got %0d required <= %0d", issued - beats, DEPTH);
        end
      end
      if (prev_stall) begin
        n_cmp++;
        if (valid !== 1'b1 || cur !== prev_beat) begin
          n_bad++; $display("FAIL hold: got v=%0b %h required v=1 %h", valid, cur, prev_beat);
        end
      end
      if (valid && ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL beat: extra beat %h, none required", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_bad++; $display("FAIL beat %0d: got w=%0d j=%0d wd=%0d n=%0d required w=%0d j=%0d wd=%0d n=%0d",
                              beats, $signed(cur[28:26]), cur[25:20], cur[19:10], cur[9:0],
                              $signed(e[28:26]), e[25:20], e[19:10], e[9:0]);
          end
        end
        beats++;
      end
      prev_stall = valid && !ready;
      prev_beat = cur;
    end
  end

  // reference model: beat order is node, then word, then j (fastest)
  task automatic build_layer(input int nodes, input int words);
    int addr;
    exp_q.delete(); exp_addr_q.delete();
    beats = 0; issued = 0; prev_stall = 0;
    for (int i = 0; i < nodes; i++)
      for (int w = 0; w < words; w++)
        for (int j = 0; j < OUT; j++) begin
          addr = i * OUT + j;
          exp_addr_q.push_back(AW'(addr));
          exp_q.push_back({ram[addr], 6'(j), 10'(w), 10'(i)});
        end
  endtask

  task automatic fill_ram_mod8();
    for (int a = 0; a < (1<<AW); a++) ram[a] = 3'(a);
  endtask

  task automatic fill_ram_random();
    for (int a = 0; a < (1<<AW); a++) ram[a] = 3'($urandom_range(0, 7));
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic pulse_start(input int nodes, input int words);
    in_nodes = 10'(nodes); ct_words = 10'(words); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; ready = 0; in_nodes = 0; ct_words = 0;
    tick(); tick();
    sample();
    n_cmp++;
    if ({busy, done, rd_en, rd_addr, valid, w_out, j_idx, w_idx, n_idx} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got busy=%0b done=%0b en=%0b valid=%0b required all 0", busy, done, rd_en, valid);
    end
    rst = 1'b0;
    tick();
    sample();
    n_cmp++;
    if ({busy, done, rd_en, valid} !== 4'b0) begin
      n_bad++; $display("FAIL idle_after_reset: got %b required 0000", {busy, done, rd_en, valid});
    end
  endtask

  task automatic test_basic();
    int first_v = -1, done_cyc = -1, last_cyc = -1, gaps = 0;
    bit busy_last = 0, busy_done = 1;
    fill_ram_mod8();
    build_layer(2, 3);
    ready = 1'b1; sb_en = 1;
    pulse_start(2, 3);
    for (int cyc = 1; cyc < 200 && done_cyc < 0; cyc++) begin
      sample();
      if (valid && first_v < 0) first_v = cyc;
      if (first_v >= 0 && !valid && beats < 60) gaps++;
      if (valid && beats == 60 && last_cyc < 0) begin last_cyc = cyc; busy_last = busy; end
      if (done) begin done_cyc = cyc; busy_done = busy; end
      tick();
    end
    n_cmp++; if (first_v !== 4) begin n_bad++; $display("FAIL first_valid_cycle: got %0d required 4", first_v); end
    n_cmp++; if (gaps !== 0) begin n_bad++; $display("FAIL no_bubbles: got %0d gaps required 0", gaps); end
    n_cmp++; if (beats !== 60) begin n_bad++; $display("FAIL basic_beats: got %0d required 60", beats); end
    n_cmp++; if (done_cyc < 0 || done_cyc !== last_cyc + 1) begin n_bad++; $display("FAIL done_timing: got %0d required %0d", done_cyc, last_cyc + 1); end
    n_cmp++; if (busy_last !== 1'b1 || busy_done !== 1'b0) begin n_bad++; $display("FAIL busy_fall: got last=%0b done=%0b required 1 0", busy_last, busy_done); end
    sample();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_pulse_width: got %0b required 0", done); end
    sb_en = 0;
  endtask

  task automatic test_ready_toggle();
    bit seen_done = 0;
    build_layer(2, 3);
    ready = 1'b1; sb_en = 1;
    pulse_start(2, 3);
    for (int cyc = 1; cyc < 400 && !seen_done; cyc++) begin
      sample();
      if (done) seen_done = 1;
      tick();
      ready = ~ready;
    end
    n_cmp++; if (!seen_done || beats !== 60 || exp_q.size() !== 0) begin
      n_bad++; $display("FAIL toggle_layer: got done=%0b beats=%0d left=%0d required 1 60 0", seen_done, beats, exp_q.size());
    end
    ready = 1'b1; sb_en = 0;
  endtask

  task automatic test_stall();
    bit seen_done = 0;
    int cnt = 0;
    build_layer(2, 3);
    ready = 1'b1; sb_en = 1;
    pulse_start(2, 3);
    while (beats < 20 && cnt < 200) begin sample(); tick(); cnt++; end
    ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      sample();
      if (k == 19) begin
        n_cmp++; if (rd_en !== 1'b0 || issued - beats !== DEPTH) begin
          n_bad++; $display("FAIL stall_credit: got en=%0b outstanding=%0d required 0 %0d", rd_en, issued - beats, DEPTH);
        end
      end
      tick();
    end
    ready = 1'b1;
    for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
      sample();
      if (done) seen_done = 1;
      tick();
    end
    n_cmp++; if (!seen_done || beats !== 60 || exp_q.size() !== 0) begin
      n_bad++; $display("FAIL stall_resume: got done=%0b beats=%0d left=%0d required 1 60 0", seen_done, beats, exp_q.size());
    end
    sb_en = 0;
  endtask

  task automatic test_empty_and_busy_start();
    bit seen_done = 0;
    int dones = 0;
    build_layer(0, 3);
    sb_en = 1;
    pulse_start(0, 3);
    start = 1'b1; in_nodes = 10'd2;  // start while busy: ignored
    sample();
    n_cmp++; if ({busy, done, rd_en} !== 3'b100) begin n_bad++; $display("FAIL empty_busy: got %b required 100", {busy, done, rd_en}); end
    tick();
    start = 1'b0;
    sample();
    n_cmp++; if ({busy, done, rd_en} !== 3'b010) begin n_bad++; $display("FAIL empty_done: got %b required 010", {busy, done, rd_en}); end
    tick();
    sample();
    n_cmp++; if ({busy, done, rd_en} !== 3'b000) begin n_bad++; $display("FAIL empty_after: got %b required 000", {busy, done, rd_en}); end
    tick();
    pulse_start(4, 0);
    sample();
    n_cmp++; if ({busy, rd_en} !== 2'b10) begin n_bad++; $display("FAIL zero_words_busy: got %b required 10", {busy, rd_en}); end
    tick();
    // non-empty layer with a second start mid-run carrying other counts
    build_layer(1, 1);
    pulse_start(1, 1);
    for (int cyc = 1; cyc < 60; cyc++) begin
      start = (cyc == 5);
      in_nodes = (cyc == 5) ? 10'd5 : 10'd1;
      sample();
      if (done) dones++;
      tick();
    end
    start = 1'b0;
    n_cmp++; if (beats !== 10 || dones !== 1 || exp_q.size() !== 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL start_while_busy: got beats=%0d dones=%0d busy=%0b required 10 1 0", beats, dones, busy);
    end
    sb_en = 0;
  endtask

  task automatic test_reset_mid_layer();
    bit seen_done = 0, bad = 0;
    int cnt = 0;
    build_layer(2, 3);
    ready = 1'b1; sb_en = 1;
    pulse_start(2, 3);
    while (beats < 15 && cnt < 200) begin sample(); tick(); cnt++; end
    sb_en = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sample();
    n_cmp++;
    if ({busy, done, rd_en, rd_addr, valid, w_out, j_idx, w_idx, n_idx} !== '0) begin
      n_bad++; $display("FAIL reset_mid: got busy=%0b done=%0b en=%0b valid=%0b required all 0", busy, done, rd_en, valid);
    end
    for (int k = 0; k < 4; k++) begin tick(); sample(); if (valid || done || busy) bad = 1; end
    n_cmp++; if (bad) begin n_bad++; $display("FAIL reset_discard: got activity after reset required none"); end
    tick();
    build_layer(2, 3);
    sb_en = 1;
    pulse_start(2, 3);
    for (int cyc = 1; cyc < 200 && !seen_done; cyc++) begin
      sample();
      if (done) seen_done = 1;
      tick();
    end
    n_cmp++; if (!seen_done || beats !== 60 || exp_q.size() !== 0) begin
      n_bad++; $display("FAIL restart_layer: got done=%0b beats=%0d left=%0d required 1 60 0", seen_done, beats, exp_q.size());
    end
    sb_en = 0;
  endtask

  task automatic test_full_layer();
    bit seen_done = 0;
    fill_ram_random();
    build_layer(784, 1);
    ready = 1'b1; sb_en = 1;
    pulse_start(784, 1);
    for (int cyc = 1; cyc < 8000 && !seen_done; cyc++) begin
      if ((cyc % 97) == 0) ready = 1'(($urandom_range(0, 3)) != 0);
      sample();
      if (done) seen_done = 1;
      tick();
    end
    ready = 1'b1;
    for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
      sample();
      if (done) seen_done = 1;
      tick();
    end
    n_cmp++; if (!seen_done || beats !== 7840 || exp_q.size() !== 0) begin
      n_bad++; $display("FAIL big_layer: got done=%0b beats=%0d left=%0d required 1 7840 0", seen_done, beats, exp_q.size());
    end
    n_cmp++; if (last_addr !== 14'd7839) begin n_bad++; $display("FAIL last_addr: got %0d required 7839", last_addr); end
    sb_en = 0;
  endtask

  // final report
  initial begin
    test_reset();
    test_basic();
    test_ready_toggle();
    test_stall();
    test_empty_and_busy_start();
    test_reset_mid_layer();
    test_full_layer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
